// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, field-position and flush-state definitions
//
// Purpose: constants shared by issue_ctrl and decode_unit, plus a small
// instruction-field decoder used by the issue logic.
// Ports: none (package).
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_LD  = 4'b1000;
  localparam logic [3:0] OP_BR  = 4'b1100;

  // Field positions (LSB of each field) within a 16-bit instruction.
  localparam int OPC_LSB  = 12;
  localparam int IMMF_BIT = 11;
  localparam int RD_LSB   = 8;
  localparam int RS1_LSB  = 5;
  localparam int RS2_LSB  = 2;

  typedef enum logic {
    FL_IDLE  = 1'b0,
    FL_FLUSH = 1'b1
  } flush_state_e;

  typedef struct packed {
    logic [3:0] opc;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       wr;     // instruction writes rd
    logic       rs1v;   // rs1 is a real source
    logic       rs2v;   // rs2 is a real source
  } instr_dec_t;

  function automatic instr_dec_t decode_instr(input logic [15:0] ins);
    instr_dec_t d;
    d.opc  = ins[OPC_LSB +: 4];
    d.rd   = ins[RD_LSB +: 3];
    d.rs1  = ins[RS1_LSB +: 3];
    d.rs2  = ins[RS2_LSB +: 3];
    d.wr   = (d.opc != OP_NOP) && (d.opc != OP_BR);
    d.rs1v = (d.opc != OP_NOP);
    // rs2 shares bits with the immediate; it is only a register when immf=0.
    d.rs2v = (d.opc != OP_NOP) && !ins[IMMF_BIT];
    return d;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write latency counters
//
// Purpose: eight 2-bit countdown counters, one per architectural register.
// A load sets a counter to (latency-1); nonzero counters count down each
// cycle. A register is busy while its counter is nonzero.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   ld0_en_i/reg/val    load request from slot0 issue
//   ld1_en_i/reg/val    load request from slot1 issue
//   busy_mask_o         bit r set while register r has a pending write
module reg_scoreboard (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld0_en_i,
  input  logic [2:0] ld0_reg_i,
  input  logic [1:0] ld0_val_i,
  input  logic       ld1_en_i,
  input  logic [2:0] ld1_reg_i,
  input  logic [1:0] ld1_val_i,
  output logic [7:0] busy_mask_o
);

  logic [7:0][1:0] cnt_q;
  logic [7:0][1:0] cnt_d;

  always_comb begin
    cnt_d       = cnt_q;
    busy_mask_o = '0;
    for (int r = 0; r < 8; r++) begin
      if (cnt_q[r] != 2'd0) begin
        cnt_d[r] = cnt_q[r] - 2'd1;
      end
      // Loads override the decrement. Both slots never target the same rd
      // (issue logic blocks that), so the load order is immaterial.
      if (ld0_en_i && (ld0_reg_i == 3'(r))) begin
        cnt_d[r] = ld0_val_i;
      end
      if (ld1_en_i && (ld1_reg_i == 3'(r))) begin
        cnt_d[r] = ld1_val_i;
      end
      busy_mask_o[r] = (cnt_q[r] != 2'd0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - dual-issue scheduler and flush sequencer
//
// Purpose: decides which of the two fetched slots issue, tracks pending
// writes via reg_scoreboard, and runs the post-branch flush sequence.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   instr0_valid, instr0        slot0 (older) instruction
//   instr1_valid, instr1        slot1 (younger) instruction
//   branch_taken                one-cycle taken-branch pulse from execute
//   issue0, issue1              slot issue decisions (combinational)
//   stall                       hold fetch/decode
//   shift1                      slot1 moves into slot0 next cycle
//   flush                       squash fetch/decode contents (registered)
//   busy_mask                   registers with pending writes
module issue_ctrl
  import cpu_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int ALU_LAT      = 1,
  parameter int LD_LAT       = 2,
  parameter int MUL_LAT      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr0_valid,
  input  logic [15:0] instr0,
  input  logic        instr1_valid,
  input  logic [15:0] instr1,
  input  logic        branch_taken,
  output logic        issue0,
  output logic        issue1,
  output logic        stall,
  output logic        shift1,
  output logic        flush,
  output logic [7:0]  busy_mask
);

  // Counter reload value: latency minus one, so LAT=1 never marks busy.
  function automatic logic [1:0] lat_m1(input logic [3:0] opc);
    case (opc)
      OP_MUL:  return 2'(MUL_LAT - 1);
      OP_LD:   return 2'(LD_LAT - 1);
      default: return 2'(ALU_LAT - 1);
    endcase
  endfunction

  instr_dec_t d0;
  instr_dec_t d1;
  logic       hazard0;
  logic       hazard1;
  logic       intra;

  flush_state_e state_q, state_d;
  logic [3:0]   fcnt_q, fcnt_d;

  assign d0 = decode_instr(instr0);
  assign d1 = decode_instr(instr1);

  assign flush = (state_q == FL_FLUSH);

  // RAW on any real source, or WAW on the destination.
  assign hazard0 = (d0.rs1v && busy_mask[d0.rs1]) ||
                   (d0.rs2v && busy_mask[d0.rs2]) ||
                   (d0.wr   && busy_mask[d0.rd]);
  assign hazard1 = (d1.rs1v && busy_mask[d1.rs1]) ||
                   (d1.rs2v && busy_mask[d1.rs2]) ||
                   (d1.wr   && busy_mask[d1.rd]);

  // Dependencies between the pair itself; a branch in slot0 also keeps
  // the younger slot back since it may be on the wrong path.
  assign intra = (d0.opc == OP_BR) ||
                 (d0.wr && d1.rs1v && (d0.rd == d1.rs1)) ||
                 (d0.wr && d1.rs2v && (d0.rd == d1.rs2)) ||
                 (d0.wr && d1.wr   && (d0.rd == d1.rd));

  assign issue0 = instr0_valid && !hazard0 && !flush;
  assign issue1 = issue0 && instr1_valid && !hazard1 && !intra;
  assign stall  = (instr0_valid && !issue0) || flush;
  assign shift1 = issue0 && instr1_valid && !issue1;

  reg_scoreboard u_sb (
    .clk         (clk),
    .reset       (reset),
    .ld0_en_i    (issue0 && d0.wr),
    .ld0_reg_i   (d0.rd),
    .ld0_val_i   (lat_m1(d0.opc)),
    .ld1_en_i    (issue1 && d1.wr),
    .ld1_reg_i   (d1.rd),
    .ld1_val_i   (lat_m1(d1.opc)),
    .busy_mask_o (busy_mask)
  );

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      FL_IDLE: begin
        if (branch_taken) begin
          state_d = FL_FLUSH;
          fcnt_d  = 4'(FLUSH_CYCLES - 1);
        end
      end
      FL_FLUSH: begin
        if (branch_taken) begin
          fcnt_d = 4'(FLUSH_CYCLES - 1);   // restart on a new taken branch
        end else if (fcnt_q == 4'd0) begin
          state_d = FL_IDLE;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = FL_IDLE;
        fcnt_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FL_IDLE;
      fcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

endmodule
